// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared types and default widths for the systolic-array PEs.
//            Holds the accumulator FSM state enum, the default operand and
//            accumulator widths, and the neighbour-link struct.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  localparam int c_default_data_w = 8;
  localparam int c_default_acc_w  = 32;

  // Accumulator FSM state
  typedef enum logic [0:0] {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } t_acc_state;

  // Operand link between neighbouring PEs (default operand width)
  typedef struct packed {
    logic [c_default_data_w-1:0] a;
    logic [c_default_data_w-1:0] b;
    logic                        valid;
    logic                        last;
  } t_pe_fwd;

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/mac_pe_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_pe_if
// Purpose  : Bundle of the operand, forwarding and result signals of one
//            mac_pe. The master side (array controller or upstream logic)
//            drives operands and result_ready_i; the slave side is the PE.
// Ports    : a_i/b_i/valid_i/last_i/clear_i   operand stream into the PE
//            x_o/y_o/valid_o/last_o           registered forwarding outputs
//            result_o/result_sat_o/result_valid_o/result_ready_i  result port
//            overrun_o                        sticky result-overwrite flag
// Revision : 1.0 - initial release
// ============================================================================
interface mac_pe_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);

  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic              valid_i;
  logic              last_i;
  logic              clear_i;
  logic [DATA_W-1:0] x_o;
  logic [DATA_W-1:0] y_o;
  logic              valid_o;
  logic              last_o;
  logic [ACC_W-1:0]  result_o;
  logic              result_sat_o;
  logic              result_valid_o;
  logic              result_ready_i;
  logic              overrun_o;

  modport master (
    output a_i, b_i, valid_i, last_i, clear_i, result_ready_i,
    input  x_o, y_o, valid_o, last_o, result_o, result_sat_o,
           result_valid_o, overrun_o
  );

  modport slave (
    input  a_i, b_i, valid_i, last_i, clear_i, result_ready_i,
    output x_o, y_o, valid_o, last_o, result_o, result_sat_o,
           result_valid_o, overrun_o
  );

endinterface : mac_pe_if
`default_nettype wire

// File: rtl/mac_pe_acc.sv
`default_nettype none
// ============================================================================
// Module   : mac_pe_acc
// Purpose  : Stage-2 of the MAC PE. Extends the registered product to the
//            accumulator width, adds it to the running sum with overflow
//            detection and optional clamping, and sequences dot products
//            with a two-state FSM. Emits a one-cycle result load strobe.
// Ports    : clk, rst      clock, synchronous active-high reset
//            i_clear       abort the accumulation in progress
//            i_pvalid      product valid
//            i_plast       product is the last term of the dot product
//            i_prod        full-width product
//            o_res_load    result strobe (one cycle)
//            o_res_data    completed dot product
//            o_res_sat     overflow occurred in this dot product
// Revision : 1.0 - initial release
// ============================================================================
module mac_pe_acc
  import systolic_pkg::*;
#(
  parameter int PROD_W   = 16,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_clear,
  input  wire logic              i_pvalid,
  input  wire logic              i_plast,
  input  wire logic [PROD_W-1:0] i_prod,
  output logic                   o_res_load,
  output logic [ACC_W-1:0]       o_res_data,
  output logic                   o_res_sat
);

  t_acc_state       r_state;
  t_acc_state       w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_sat_next;

  logic             w_pvalid;
  logic             w_ext_sgn;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum_full;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_clamp;
  logic [ACC_W-1:0] w_add_res;

  // A clear discards whatever product is currently in stage 1
  assign w_pvalid  = i_pvalid && !i_clear;
  assign w_ext_sgn = (SIGNED != 0) && i_prod[PROD_W-1];

  generate
    if (ACC_W > PROD_W) begin : g_ext
      assign w_ext = {{(ACC_W-PROD_W){w_ext_sgn}}, i_prod};
    end else begin : g_noext
      assign w_ext = i_prod;
    end
  endgenerate

  assign w_sum_full = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_sum      = w_sum_full[ACC_W-1:0];

  // Signed: both addends share a sign that the sum does not.
  // Unsigned: carry out of the top bit (addends are never negative).
  always_comb begin
    w_ovf   = 1'b0;
    w_clamp = '1;
    if (SIGNED != 0) begin
      w_ovf   = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
      w_clamp = r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      w_ovf   = w_sum_full[ACC_W];
      w_clamp = '1;
    end
  end

  // A clamped accumulator re-overflows on same-sign terms and therefore
  // stays clamped; opposite-sign terms cannot overflow and add normally.
  assign w_add_res = (w_ovf && (SATURATE != 0)) ? w_clamp : w_sum;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_state <= ACC_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACC_IDLE:  if (w_pvalid && !i_plast) w_state_next = ACC_ACCUM;
      ACC_ACCUM: if (w_pvalid && i_plast)  w_state_next = ACC_IDLE;
      default:   w_state_next = ACC_IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    w_acc_next = r_acc;
    w_sat_next = r_sat;
    o_res_load = 1'b0;
    o_res_data = '0;
    o_res_sat  = 1'b0;
    case (r_state)
      ACC_IDLE: begin
        if (w_pvalid) begin
          // First term fits in ACC_W bits, so no overflow is possible
          w_acc_next = w_ext;
          w_sat_next = 1'b0;
          if (i_plast) begin
            o_res_load = 1'b1;
            o_res_data = w_ext;
            o_res_sat  = 1'b0;
          end
        end
      end
      ACC_ACCUM: begin
        if (w_pvalid) begin
          w_acc_next = w_add_res;
          w_sat_next = r_sat || w_ovf;
          if (i_plast) begin
            o_res_load = 1'b1;
            o_res_data = w_add_res;
            o_res_sat  = r_sat || w_ovf;
          end
        end
      end
      default: begin
        w_acc_next = '0;
        w_sat_next = 1'b0;
      end
    endcase
  end

  // Accumulator and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      r_sat <= w_sat_next;
    end
  end

endmodule : mac_pe_acc
`default_nettype wire

// File: rtl/mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : mac_pe
// Purpose  : Accumulating systolic processing element. Forwards operands to
//            the east/south neighbours with one cycle of latency, multiplies
//            valid operand pairs (stage 1), accumulates tagged dot products
//            (stage 2, mac_pe_acc) and presents finished sums on a
//            valid/ready result port with sticky overrun detection.
// Ports    : clock_i   system clock
//            reset_i   synchronous active-high reset
//            bus       mac_pe_if slave: operands, forwarding, result port
// Revision : 1.0 - initial release
// ============================================================================
module mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W   = c_default_data_w,
  parameter int ACC_W    = c_default_acc_w,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input wire logic clock_i,
  input wire logic reset_i,
  mac_pe_if.slave  bus
);

  localparam int PROD_W = 2 * DATA_W;

  generate
    if (ACC_W < PROD_W) begin : g_bad_acc_w
      $error("mac_pe: ACC_W must be at least 2*DATA_W");
    end
  endgenerate

  // Forwarding registers
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic              r_valid;
  logic              r_last;

  // Stage 1
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [PROD_W-1:0] w_a_ext;
  logic [PROD_W-1:0] w_b_ext;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] r_prod;
  logic              r_pvalid;
  logic              r_plast;

  // Stage 2 / result
  logic              w_res_load;
  logic [ACC_W-1:0]  w_res_data;
  logic              w_res_sat;
  logic [ACC_W-1:0]  r_result;
  logic              r_result_sat;
  logic              r_result_valid;
  logic              r_overrun;
  logic              w_handshake;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_x     <= bus.a_i;
      r_y     <= bus.b_i;
      r_valid <= bus.valid_i;
      r_last  <= bus.last_i && bus.valid_i;
    end
  end

  // Extending both operands to the product width first makes the low
  // PROD_W bits of an unsigned multiply the correct signed product.
  assign w_a_sgn = (SIGNED != 0) && bus.a_i[DATA_W-1];
  assign w_b_sgn = (SIGNED != 0) && bus.b_i[DATA_W-1];
  assign w_a_ext = {{DATA_W{w_a_sgn}}, bus.a_i};
  assign w_b_ext = {{DATA_W{w_b_sgn}}, bus.b_i};
  assign w_prod  = w_a_ext * w_b_ext;

  // A pair presented during clear_i is captured here; stage 2 ignores the
  // older product it is holding in that same cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_prod   <= '0;
      r_pvalid <= 1'b0;
      r_plast  <= 1'b0;
    end else begin
      r_pvalid <= bus.valid_i;
      r_plast  <= bus.valid_i && bus.last_i;
      if (bus.valid_i) begin
        r_prod <= w_prod;
      end
    end
  end

  mac_pe_acc #(
    .PROD_W   (PROD_W),
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_acc (
    .clk        (clock_i),
    .rst        (reset_i),
    .i_clear    (bus.clear_i),
    .i_pvalid   (r_pvalid),
    .i_plast    (r_plast),
    .i_prod     (r_prod),
    .o_res_load (w_res_load),
    .o_res_data (w_res_data),
    .o_res_sat  (w_res_sat)
  );

  assign w_handshake = r_result_valid && bus.result_ready_i;

  // Result register: a new result always wins; losing an unaccepted one
  // raises the sticky overrun flag, which only clear_i or reset drops.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_result       <= '0;
      r_result_sat   <= 1'b0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (w_res_load) begin
        r_result       <= w_res_data;
        r_result_sat   <= w_res_sat;
        r_result_valid <= 1'b1;
      end else if (w_handshake) begin
        r_result_valid <= 1'b0;
      end

      if (bus.clear_i) begin
        r_overrun <= 1'b0;
      end else if (w_res_load && r_result_valid && !bus.result_ready_i) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.x_o            = r_x;
  assign bus.y_o            = r_y;
  assign bus.valid_o        = r_valid;
  assign bus.last_o         = r_last;
  assign bus.result_o       = r_result;
  assign bus.result_sat_o   = r_result_sat;
  assign bus.result_valid_o = r_result_valid;
  assign bus.overrun_o      = r_overrun;

endmodule : mac_pe
`default_nettype wire
